bmu_pipe: RTL
=============

# bmu_pipe

Parametrised, pipelined bit-manipulation unit with valid/ready handshakes on both sides and a saturating error counter. It is the next-generation BMU execution block. It adds configurable data width and latency, back-pressure from the consumer, and an encoded opcode in place of a one-hot predecode packet. It sits in the execute stage between the issue logic and the writeback arbiter.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- LATENCY, 2, pipeline stages from accept to valid_out; 1..4.
- ERRW, 16, width of err_count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- valid_in  in  1  request valid.
- ready_out  out  1  unit can accept a request this cycle.
- op  in  4  operation code (see Operation).
- csr_ren_in  in  1  CSR read; result = csr_rddata_in, op ignored.
- csr_rddata_in  in  XLEN  CSR read data.
- a_in  in  XLEN  operand A (signed where noted).
- b_in  in  XLEN  operand B.
- valid_out  out  1  result valid.
- ready_in  in  1  consumer accepts result.
- result_ff  out  XLEN  registered result.
- error  out  1  registered error flag, qualified by valid_out.
- err_count  out  ERRW  saturating count of delivered errored results.

## Operation
- Accept: a request is accepted on a rising edge when valid_in && ready_out.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 ANDN (a & ~b).
  - 4 SLL, 5 SRL, 6 SRA (arithmetic, signed a).
  - 7 ROL, 8 ROR.
  - 9 CLZ, 10 CTZ, 11 CPOP.
  - 12 SEXT_B (sign-extend a[7:0]).
  - 13 MIN, 14 MAX (signed compare).
  - 15 reserved.
- Shift/rotate amount is b_in[$clog2(XLEN)-1:0]. Upper bits of b_in are ignored.
- CLZ(0) = CTZ(0) = XLEN. CLZ, CTZ and CPOP results are zero-extended to XLEN.
- Errors:
  - op 15 with csr_ren_in=0: error=1, result=0.
  - csr_ren_in=1: error=0 regardless of op.
- Datapath: the result is computed combinationally in stage 1, then carried through LATENCY-1 further register stages. Each stage holds {valid, result, error}.
- Stall: stall = valid_out && !ready_in. While stalled, all stages hold and ready_out=0.
  - ready_out = !stall. No bubble collapsing.
- Delivery: a result is delivered when valid_out && ready_in.
- err_count increments by 1 on each delivery with error=1. It saturates at 2^ERRW-1 and never wraps.
- Reset: asserting rst_l=0 at any time clears all stage valids and data immediately. In-flight requests are dropped.
- Reset values of outputs:
  - valid_out=0, result_ff=0, error=0, err_count=0.
  - ready_out=1 during and after reset.

## Timing
- Latency: a request accepted at edge N appears with valid_out=1 after edge N+LATENCY-1, i.e. it is visible in the cycle following the LATENCY-th edge including N, provided there is no stall.
- Throughput: 1 request per cycle while ready_in=1.
- Stall response: when ready_in deasserts with valid_out=1, ready_out drops in the same cycle (combinational). No request is lost or duplicated.
- Stability: result_ff and error stay stable while valid_out && !ready_in.
- Simultaneous events: delivery and accept in the same cycle are legal. At full throughput the pipeline shifts by one.
- Saturation: when err_count is saturated and an errored delivery occurs, it holds at max.

## Configuration
- BMU_ROTATE_EN defined: opcodes 7 (ROL) and 8 (ROR) execute as specified.
- BMU_ROTATE_EN undefined: opcodes 7 and 8 behave as reserved (error=1, result=0), and the rotate logic is absent.

## Test plan
All scenarios use XLEN=32, LATENCY=2, ERRW=16, BMU_ROTATE_EN defined, ready_in=1 unless stated.
- Reset then idle -> valid_out=0, result_ff=0, error=0, err_count=0, ready_out=1.
- Op 11 (CPOP), a=0xF0F0_0001 -> result 0x9 with error=0, arriving exactly 2 edges after accept. Op 9 (CLZ), a=0 -> 32.
- Op 6 (SRA), a=0x8000_0000, b=0x24 (amount 4) -> 0xF800_0000. Op 7 (ROL), a=0x8000_0001, b=1 -> 0x0000_0003.
- Back-pressure: stream 4 back-to-back ops (XOR, a=i, b=0xFF), hold ready_in=0 for 3 cycles mid-stream -> ready_out=0 for those cycles, all 4 results delivered in order, none duplicated.
- Error counting: op 15 sent 3 times, plus csr_ren_in=1 with op=15 and csr_rddata_in=0x1234 -> three error=1 results, then 0x1234 with error=0; err_count=3. Force err_count=0xFFFF, send one more error -> count holds at 0xFFFF.
- Assert rst_l=0 mid-stream with 2 requests in flight -> valid_out drops to 0 immediately and no stale result appears after rst_l=1.

Source files
------------

// File: rtl/bmu_pipe.sv
// Pipelined bit-manipulation unit (logic, shift, rotate, count, sext, min/max) with a saturating error counter.
// Latency: LATENCY cycles from accept to valid_out. Rotates exist only with BMU_ROTATE_EN defined.
// Backpressure: the whole pipe freezes while valid_out && !ready_in, and ready_out drops in that same cycle.
module bmu_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int ERRW    = 16
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [3:0]      op,
    input  logic            csr_ren_in,
    input  logic [XLEN-1:0] csr_rddata_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result_ff,
    output logic            error,
    output logic [ERRW-1:0] err_count
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ANDN = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_CLZ  = 4'd9;
    localparam logic [3:0] OP_CTZ  = 4'd10;
    localparam logic [3:0] OP_CPOP = 4'd11;
    localparam logic [3:0] OP_SEXT = 4'd12;
    localparam logic [3:0] OP_MIN  = 4'd13;
    localparam logic [3:0] OP_MAX  = 4'd14;

    typedef struct packed {
        logic            vld;
        logic            err;
        logic [XLEN-1:0] dat;
    } stage_t;

    logic [SHW-1:0]  shamt;
    logic [CW-1:0]   clz_cnt;
    logic [CW-1:0]   ctz_cnt;
    logic [CW-1:0]   cpop_cnt;
    logic [XLEN-1:0] res_c;
    logic            err_c;
    logic            stall;
    logic            deliver;
    stage_t          stg [LATENCY];

    assign shamt = b_in[SHW-1:0];

`ifdef BMU_ROTATE_EN
    localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);
    logic [SHW:0]    rsh;
    logic [XLEN-1:0] rol_c;
    logic [XLEN-1:0] ror_c;

    // A zero amount makes the complementary shift equal XLEN, which yields 0.
    assign rsh   = XLEN_W - {1'b0, shamt};
    assign rol_c = (a_in << shamt) | (a_in >> rsh);
    assign ror_c = (a_in >> shamt) | (a_in << rsh);
`endif

    always_comb begin
        clz_cnt  = CW'(XLEN);
        ctz_cnt  = CW'(XLEN);
        cpop_cnt = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (a_in[i]) clz_cnt = CW'(XLEN - 1 - i);
            cpop_cnt = cpop_cnt + CW'(a_in[i]);
        end
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (a_in[i]) ctz_cnt = CW'(i);
        end
    end

    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        if (csr_ren_in) begin
            res_c = csr_rddata_in;
        end else begin
            case (op)
                OP_AND:  res_c = a_in & b_in;
                OP_OR:   res_c = a_in | b_in;
                OP_XOR:  res_c = a_in ^ b_in;
                OP_ANDN: res_c = a_in & ~b_in;
                OP_SLL:  res_c = a_in << shamt;
                OP_SRL:  res_c = a_in >> shamt;
                OP_SRA:  res_c = $unsigned($signed(a_in) >>> shamt);
`ifdef BMU_ROTATE_EN
                OP_ROL:  res_c = rol_c;
                OP_ROR:  res_c = ror_c;
`endif
                OP_CLZ:  res_c = XLEN'(clz_cnt);
                OP_CTZ:  res_c = XLEN'(ctz_cnt);
                OP_CPOP: res_c = XLEN'(cpop_cnt);
                OP_SEXT: res_c = {{(XLEN-8){a_in[7]}}, a_in[7:0]};
                OP_MIN:  res_c = ($signed(a_in) < $signed(b_in)) ? a_in : b_in;
                OP_MAX:  res_c = ($signed(a_in) < $signed(b_in)) ? b_in : a_in;
                default: err_c = 1'b1;
            endcase
        end
    end

    assign valid_out = stg[LATENCY-1].vld;
    assign result_ff = stg[LATENCY-1].dat;
    assign error     = stg[LATENCY-1].err;
    assign stall     = valid_out && !ready_in;
    assign ready_out = !stall;
    assign deliver   = valid_out && ready_in;

    // Bubbles carry zero data so an idle output reads back as zero.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
        end else if (!stall) begin
            stg[0] <= valid_in ? stage_t'{1'b1, err_c, res_c} : '0;
            for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_count <= '0;
        end else if (deliver && error && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
